if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] are treated as 00.
REQ-002 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, reset; synchronous and active-high.
REQ-004 Port stall, input, 1 bit, load-use hold request from the hazard unit.
REQ-005 Port redirect, input, 1 bit, taken branch or jump resolved in ID (comparator equal AND Branch).
REQ-006 Port redirect_target, input, 32 bits, branch or jump destination computed in ID.
REQ-007 Port imem_addr, output, 32 bits, instruction memory address; combinationally equal to the PC register.
REQ-008 Port imem_data, input, 32 bits, instruction word from asynchronous-read instruction memory.
REQ-009 Port IF_ID_instru, output, 32 bits, registered raw instruction presented to the ID register file and decoder.
REQ-010 Port IF_ID_PC4, output, 32 bits, registered PC+4 of the held instruction.
REQ-011 Port IF_ID_valid, output, 1 bit, 1 when the IF/ID register holds a real instruction and 0 when it holds a bubble.

Function
REQ-012 The block SHALL hold a 32-bit PC register and a 65-bit IF/ID register (instru, PC4, valid).
REQ-013 Per-edge priority SHALL be: rst, then stall, then redirect, then normal.
REQ-014 Normal edge: PC <= PC+4; IF_ID_instru <= imem_data; IF_ID_PC4 <= PC+4; IF_ID_valid <= 1.
REQ-015 Stall edge: PC and the whole IF/ID register SHALL hold their values; redirect is ignored on that edge and the hazard unit must re-assert it.
REQ-016 Redirect edge (stall=0): PC <= {redirect_target[31:2],2'b00}; IF_ID_instru <= 32'h0000_0000 (nop); IF_ID_PC4 <= 0; IF_ID_valid <= 0.
REQ-017 Redirect SHALL cost exactly one bubble cycle, with no delay slot.
REQ-018 The instruction at the target SHALL appear on IF_ID_instru on the second edge after redirect is sampled.
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no error indication.
REQ-020 Back-to-back redirects SHALL each be honoured, producing consecutive bubbles.
REQ-021 imem_addr[1:0] SHALL always be 00.
REQ-022 The block SHALL contain no combinational path from stall or redirect to imem_addr.

Reset
REQ-023 On an edge with rst=1, the block SHALL set PC <= {RESET_PC[31:2],2'b00}, IF_ID_instru <= 0, IF_ID_PC4 <= 0 and IF_ID_valid <= 0.
REQ-024 Reset SHALL override stall and redirect, including when asserted mid-stall or mid-redirect.
REQ-025 The first edge after rst deasserts SHALL latch the instruction at RESET_PC.
REQ-026 Before the first reset edge, outputs are unspecified, and the bench SHALL NOT check them.

Configuration
REQ-027 Macro IF_FETCH_CNT_EN: when defined, the block SHALL add output fetch_cnt (32 bits), incremented on every edge that loads IF_ID_valid <= 1 and cleared by rst.
REQ-028 The fetch_cnt count SHALL wrap modulo 2^32 and hold on stall and redirect edges.
REQ-029 When IF_FETCH_CNT_EN is undefined, the fetch_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Reset then run: rst=1 for 2 cycles with RESET_PC=0, memory word 0 = 32'h2008_0005 -> after the first free edge, IF_ID_instru=32'h2008_0005, IF_ID_PC4=4, imem_addr=4, IF_ID_valid=1.
REQ-031 Stall hold: stall=1 for 3 edges at PC=8 -> imem_addr stays 8 and the IF/ID register is unchanged; releasing stall resumes with PC=12.
REQ-032 Redirect: redirect=1 with redirect_target=32'h0000_0043 at PC=16 -> next edge gives IF_ID_valid=0, IF_ID_instru=0, imem_addr=32'h40; the following edge latches mem[0x40] with IF_ID_PC4=32'h44.
REQ-033 Stall and redirect together: both asserted -> no change on that edge; redirect alone on the next edge then takes effect per REQ-032.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC -> after the first free edge, IF_ID_PC4=0 and imem_addr=0.
REQ-035 Counter (IF_FETCH_CNT_EN defined): 5 normal edges, 1 redirect and 2 stalls -> fetch_cnt=5; rst asserted mid-sequence -> fetch_cnt=0 on the following cycle.

Source files
------------

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Brief    : Instruction-fetch stage. Holds the PC and the IF/ID pipeline
//             register. It resolves stall, redirect and sequential fetch.
//             Optional build macro IF_FETCH_CNT_EN adds a 32-bit fetch_cnt
//             output that counts valid instructions loaded into IF/ID.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] IF_ID_instru,
    output logic [31:0] IF_ID_PC4,
`ifdef IF_FETCH_CNT_EN
    output logic [31:0] fetch_cnt,
`endif
    output logic        IF_ID_valid
);

    // Word alignment is forced on every PC source, so imem_addr[1:0] stays 00.
    localparam logic [31:0] c_WORD_MASK        = 32'hFFFF_FFFC;
    localparam logic [31:0] c_RESET_PC_ALIGNED = RESET_PC & c_WORD_MASK;
    localparam logic [31:0] c_NOP              = 32'h0000_0000;

    logic [31:0] r_pc;
    logic [31:0] r_ifIdInstru;
    logic [31:0] r_ifIdPc4;
    logic        r_ifIdValid;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_redirectPc;

    // Sequential increment wraps naturally modulo 2^32.
    assign w_pcPlus4    = r_pc + 32'd4;
    assign w_redirectPc = redirect_target & c_WORD_MASK;

    // imem_addr depends only on a register. There is no path from stall or redirect.
    assign imem_addr    = r_pc;
    assign IF_ID_instru = r_ifIdInstru;
    assign IF_ID_PC4    = r_ifIdPc4;
    assign IF_ID_valid  = r_ifIdValid;

    // PC update: reset, then stall hold, then redirect, then sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= c_RESET_PC_ALIGNED;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (redirect) begin
            r_pc <= w_redirectPc;
        end else begin
            r_pc <= w_pcPlus4;
        end
    end

    // IF/ID register: a redirect loads a bubble, so the taken path costs one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifIdInstru <= c_NOP;
            r_ifIdPc4    <= 32'd0;
            r_ifIdValid  <= 1'b0;
        end else if (stall) begin
            r_ifIdInstru <= r_ifIdInstru;
            r_ifIdPc4    <= r_ifIdPc4;
            r_ifIdValid  <= r_ifIdValid;
        end else if (redirect) begin
            r_ifIdInstru <= c_NOP;
            r_ifIdPc4    <= 32'd0;
            r_ifIdValid  <= 1'b0;
        end else begin
            r_ifIdInstru <= imem_data;
            r_ifIdPc4    <= w_pcPlus4;
            r_ifIdValid  <= 1'b1;
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [31:0] r_fetchCnt;

    assign fetch_cnt = r_fetchCnt;

    // Count edges that load a real instruction. Stall and redirect edges hold the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchCnt <= 32'd0;
        end else if (!stall && !redirect) begin
            r_fetchCnt <= r_fetchCnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Brief    : Self-checking bench for if_fetch_stage. It uses a table of
//             hand-derived vectors and a scoreboard queue of expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] expAddr;
        logic [31:0] expInstru;
        logic [31:0] expPc4;
        logic        expValid;
        logic [31:0] expCnt;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instru;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] imemAddrA, imemDataA, instruA, pc4A;
    logic        validA;
    logic [31:0] imemAddrB, imemDataB, instruB, pc4B;
    logic        validB;
    logic        stallB    = 1'b0;
    logic        redirectB = 1'b0;
    logic [31:0] targetB   = 32'd0;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetchCntA, fetchCntB;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    exp_t sbQ[$];
    vec_t tab[22];

    always #5 clk = ~clk;

    // Instruction memory: word 0 is addi, all other words are address ^ C000_0000.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        return a ^ 32'hC000_0000;
    endfunction

    assign imemDataA = memWord(imemAddrA);
    assign imemDataB = memWord(imemAddrB);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dutA (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirectTarget), .imem_addr(imemAddrA),
        .imem_data(imemDataA), .IF_ID_instru(instruA), .IF_ID_PC4(pc4A),
`ifdef IF_FETCH_CNT_EN
        .fetch_cnt(fetchCntA),
`endif
        .IF_ID_valid(validA)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutB (
        .clk(clk), .rst(rst), .stall(stallB), .redirect(redirectB),
        .redirect_target(targetB), .imem_addr(imemAddrB),
        .imem_data(imemDataB), .IF_ID_instru(instruB), .IF_ID_PC4(pc4B),
`ifdef IF_FETCH_CNT_EN
        .fetch_cnt(fetchCntB),
`endif
        .IF_ID_valid(validB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the current instance-A outputs.
    task automatic compareA();
        exp_t e;
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sbQ.pop_front();
        check({e.tag, ".imem_addr"}, imemAddrA, e.addr);
        check({e.tag, ".instru"},    instruA,   e.instru);
        check({e.tag, ".pc4"},       pc4A,      e.pc4);
        check({e.tag, ".valid"},     {31'd0, validA}, {31'd0, e.valid});
`ifdef IF_FETCH_CNT_EN
        check({e.tag, ".fetch_cnt"}, fetchCntA, e.cnt);
`endif
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] t, input logic [31:0] a,
                                input logic [31:0] ins, input logic [31:0] p4,
                                input logic v, input logic [31:0] c);
        vec_t x;
        x.rst = r; x.stall = s; x.redirect = rd; x.target = t;
        x.expAddr = a; x.expInstru = ins; x.expPc4 = p4; x.expValid = v; x.expCnt = c;
        return x;
    endfunction

    initial begin
        exp_t e;
        //             rst stall redir target        addr          instru        pc4           v  cnt
        tab[0]  = mk(0, 0, 0, 32'h0,         32'h4,        32'h2008_0005, 32'h4,        1, 1);
        tab[1]  = mk(0, 0, 0, 32'h0,         32'h8,        32'hC000_0004, 32'h8,        1, 2);
        tab[2]  = mk(0, 1, 0, 32'h0,         32'h8,        32'hC000_0004, 32'h8,        1, 2);
        tab[3]  = mk(0, 1, 0, 32'h0,         32'h8,        32'hC000_0004, 32'h8,        1, 2);
        tab[4]  = mk(0, 1, 0, 32'h0,         32'h8,        32'hC000_0004, 32'h8,        1, 2);
        tab[5]  = mk(0, 0, 0, 32'h0,         32'hC,        32'hC000_0008, 32'hC,        1, 3);
        tab[6]  = mk(0, 0, 0, 32'h0,         32'h10,       32'hC000_000C, 32'h10,       1, 4);
        tab[7]  = mk(0, 0, 1, 32'h43,        32'h40,       32'h0,         32'h0,        0, 4);
        tab[8]  = mk(0, 0, 0, 32'h0,         32'h44,       32'hC000_0040, 32'h44,       1, 5);
        tab[9]  = mk(0, 1, 1, 32'h100,       32'h44,       32'hC000_0040, 32'h44,       1, 5);
        tab[10] = mk(0, 0, 1, 32'h100,       32'h100,      32'h0,         32'h0,        0, 5);
        tab[11] = mk(0, 0, 1, 32'h204,       32'h204,      32'h0,         32'h0,        0, 5);
        tab[12] = mk(0, 0, 0, 32'h0,         32'h208,      32'hC000_0204, 32'h208,      1, 6);
        tab[13] = mk(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,        32'h0,        0, 6);
        tab[14] = mk(0, 0, 0, 32'h0,         32'h0,        32'h3FFF_FFFC, 32'h0,        1, 7);
        tab[15] = mk(0, 0, 0, 32'h0,         32'h4,        32'h2008_0005, 32'h4,        1, 8);
        tab[16] = mk(1, 1, 0, 32'h0,         32'h0,        32'h0,         32'h0,        0, 0);
        tab[17] = mk(0, 0, 0, 32'h0,         32'h4,        32'h2008_0005, 32'h4,        1, 1);
        tab[18] = mk(0, 0, 0, 32'h0,         32'h8,        32'hC000_0004, 32'h8,        1, 2);
        tab[19] = mk(1, 0, 1, 32'h80,        32'h0,        32'h0,         32'h0,        0, 0);
        tab[20] = mk(0, 0, 1, 32'h80,        32'h80,       32'h0,         32'h0,        0, 0);
        tab[21] = mk(0, 0, 0, 32'h0,         32'h84,       32'hC000_0080, 32'h84,       1, 1);

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'd0;

        // Two reset cycles, then check the reset state of both instances.
        repeat (2) @(posedge clk);
        e = '{tag:"reset", addr:32'h0, instru:32'h0, pc4:32'h0, valid:1'b0, cnt:32'h0};
        sbQ.push_back(e);
        #1;
        compareA();
        check("resetB.imem_addr", imemAddrB, 32'hFFFF_FFFC);
        check("resetB.valid", {31'd0, validB}, 32'd0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rst = tab[i].rst; stall = tab[i].stall;
            redirect = tab[i].redirect; redirectTarget = tab[i].target;
            e = '{tag:$sformatf("step%0d", i), addr:tab[i].expAddr, instru:tab[i].expInstru,
                  pc4:tab[i].expPc4, valid:tab[i].expValid, cnt:tab[i].expCnt};
            sbQ.push_back(e);
            @(posedge clk);
            #1;
            compareA();
            if (i == 0) begin
                // The first free edge from RESET_PC FFFF_FFFC wraps PC+4 to zero.
                check("wrapB.imem_addr", imemAddrB, 32'h0);
                check("wrapB.pc4",       pc4B,      32'h0);
                check("wrapB.instru",    instruB,   32'h3FFF_FFFC);
                check("wrapB.valid",     {31'd0, validB}, 32'd1);
            end
        end

        // Mid-cycle toggling of stall or redirect must not disturb imem_addr.
        @(negedge clk);
        rst = 1'b0; stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h300;
        #1;
        check("nocomb.imem_addr", imemAddrA, 32'h84);
        stall = 1'b0;
        #1;
        check("nocomb2.imem_addr", imemAddrA, 32'h84);
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check("nocomb3.imem_addr", imemAddrA, 32'h88);
        check("nocomb3.instru",    instruA,   32'hC000_0084);

        check("scoreboard_drained", sbQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
`default_nettype wire
